// File: rtl/intcalc_seq.sv
`default_nettype none
// ============================================================================
//  Module      : intcalc_seq
//  Description : Sequential integer multiply/divide unit. It does one operand
//                bit per cycle: shift-add for multiply and restoring subtract
//                for divide, both on operand magnitudes. A final FIXUP cycle
//                applies the sign correction and selects the low or high half.
//                A zero divisor and the reserved function skip the iterative
//                phase.
//                Optional macro INTCALC_SEQ_FASTMUL_EN: multiplies use a
//                single-cycle combinational multiplier and skip the iterative
//                phase.
//  Revision    : 1.0 - initial release
// ============================================================================
module intcalc_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [2:0]       func_i,
    input  logic [WIDTH-1:0] in1_i,
    input  logic [WIDTH-1:0] in2_i,
    input  logic             flush_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             divzero_o,
    output logic             stall_o
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [2:0] c_fn_mul   = 3'd0;
    localparam logic [2:0] c_fn_mulh  = 3'd1;
    localparam logic [2:0] c_fn_mulhu = 3'd2;
    localparam logic [2:0] c_fn_div   = 3'd3;
    localparam logic [2:0] c_fn_divu  = 3'd4;
    localparam logic [2:0] c_fn_mod   = 3'd5;
    localparam logic [2:0] c_fn_modu  = 3'd6;
    localparam logic [2:0] c_fn_rsvd  = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_FIXUP = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [2:0]         r_func;
    logic               r_neg_a;
    logic               r_neg_b;
    logic               r_zero_div;
    logic               r_dz;
    logic [WIDTH-1:0]   r_in1;
    logic [WIDTH-1:0]   r_opnd;      // multiplicand (mul) or divisor (div) magnitude
    logic [2*WIDTH-1:0] r_acc;       // {high/remainder, low/quotient}
    logic [CW-1:0]      r_cnt;

    // Input decode used at the acceptance edge
    logic               w_is_mul;
    logic               w_is_div;
    logic               w_signed;
    logic               w_sa;
    logic               w_sb;
    logic [WIDTH-1:0]   w_mag1;
    logic [WIDTH-1:0]   w_mag2;
    logic               w_zero_div;
    logic               w_bypass;
    logic               w_accept;

    assign w_is_mul   = (func_i == c_fn_mul) | (func_i == c_fn_mulh) | (func_i == c_fn_mulhu);
    assign w_is_div   = (func_i == c_fn_div) | (func_i == c_fn_divu) |
                        (func_i == c_fn_mod) | (func_i == c_fn_modu);
    assign w_signed   = (func_i == c_fn_mulh) | (func_i == c_fn_div) | (func_i == c_fn_mod);
    assign w_sa       = w_signed & in1_i[WIDTH-1];
    assign w_sb       = w_signed & in2_i[WIDTH-1];
    assign w_mag1     = w_sa ? -in1_i : in1_i;
    assign w_mag2     = w_sb ? -in2_i : in2_i;
    assign w_zero_div = w_is_div & (in2_i == '0);
    assign w_accept   = start_i & ((r_state == S_IDLE) | (r_state == S_DONE)) & ~flush_i;

`ifdef INTCALC_SEQ_FASTMUL_EN
    logic [2*WIDTH-1:0] w_fast_prod;
    assign w_fast_prod = {{WIDTH{1'b0}}, w_mag1} * {{WIDTH{1'b0}}, w_mag2};
    assign w_bypass    = w_zero_div | (func_i == c_fn_rsvd) | w_is_mul;
`else
    assign w_bypass    = w_zero_div | (func_i == c_fn_rsvd);
`endif

    // One iteration step for each algorithm
    logic               r_is_mul;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_nxt;
    logic [WIDTH:0]     w_rem_sh;
    logic               w_ge;
    logic [WIDTH-1:0]   w_rem_sub;
    logic [2*WIDTH-1:0] w_div_nxt;

    assign r_is_mul  = (r_func == c_fn_mul) | (r_func == c_fn_mulh) | (r_func == c_fn_mulhu);
    assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    assign w_mul_nxt = {w_mul_sum, r_acc[WIDTH-1:1]};
    assign w_rem_sh  = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_ge      = w_rem_sh >= {1'b0, r_opnd};
    assign w_rem_sub = w_rem_sh[WIDTH-1:0] - r_opnd;
    assign w_div_nxt = {(w_ge ? w_rem_sub : w_rem_sh[WIDTH-1:0]), r_acc[WIDTH-2:0], w_ge};

    // Sign correction and half selection applied in FIXUP
    logic               w_neg;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_fix_res;

    assign w_neg  = r_neg_a ^ r_neg_b;
    assign w_prod = w_neg ? -r_acc : r_acc;
    assign w_quot = w_neg ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_rem  = r_neg_a ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

    // Final result mux; zero divisor and reserved function override the datapath
    always_comb begin
        w_fix_res = '0;
        if (r_func == c_fn_rsvd) begin
            w_fix_res = '0;
        end else if (r_zero_div) begin
            w_fix_res = ((r_func == c_fn_div) | (r_func == c_fn_divu)) ? '1 : r_in1;
        end else begin
            case (r_func)
                c_fn_mul:                   w_fix_res = w_prod[WIDTH-1:0];
                c_fn_mulh, c_fn_mulhu:      w_fix_res = w_prod[2*WIDTH-1:WIDTH];
                c_fn_div, c_fn_divu:        w_fix_res = w_quot;
                c_fn_mod, c_fn_modu:        w_fix_res = w_rem;
                default:                    w_fix_res = '0;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    // Next-state and status outputs; flush wins over everything
    always_comb begin
        w_state_nxt = r_state;
        busy_o      = (r_state == S_CALC) | (r_state == S_FIXUP);
        done_o      = (r_state == S_DONE);
        divzero_o   = (r_state == S_DONE) & r_dz;
        stall_o     = rst_ni & (busy_o | (start_i & ((r_state == S_IDLE) | (r_state == S_DONE))));
        if (flush_i) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_accept) w_state_nxt = w_bypass ? S_FIXUP : S_CALC;
                    else          w_state_nxt = S_IDLE;
                end
                S_CALC:  if (r_cnt == CW'(1)) w_state_nxt = S_FIXUP;
                S_FIXUP: w_state_nxt = S_DONE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Datapath: latch operands on accept, iterate in CALC, register result in FIXUP
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_func     <= '0;
            r_neg_a    <= 1'b0;
            r_neg_b    <= 1'b0;
            r_zero_div <= 1'b0;
            r_dz       <= 1'b0;
            r_in1      <= '0;
            r_opnd     <= '0;
            r_acc      <= '0;
            r_cnt      <= '0;
            result_o   <= '0;
        end else if (w_accept) begin
            r_func     <= func_i;
            r_neg_a    <= w_sa;
            r_neg_b    <= w_sb;
            r_zero_div <= w_zero_div;
            r_in1      <= in1_i;
            r_cnt      <= CW'(WIDTH);
            if (w_is_mul) begin
                r_opnd <= w_mag1;
`ifdef INTCALC_SEQ_FASTMUL_EN
                r_acc  <= w_fast_prod;
`else
                r_acc  <= {{WIDTH{1'b0}}, w_mag2};
`endif
            end else begin
                r_opnd <= w_mag2;
                r_acc  <= {{WIDTH{1'b0}}, w_mag1};
            end
        end else if (r_state == S_CALC) begin
            r_acc <= r_is_mul ? w_mul_nxt : w_div_nxt;
            r_cnt <= r_cnt - CW'(1);
        end else if ((r_state == S_FIXUP) && !flush_i) begin
            result_o <= w_fix_res;
            r_dz     <= r_zero_div;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_intcalc_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_intcalc_seq
//  Description : Self-checking bench for intcalc_seq (WIDTH=32). A vector
//                table plus hand-written flush, reset, ignored-start and
//                back-to-back sequences; expected results go through a queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_intcalc_seq;

    localparam int WIDTH = 32;
    localparam int c_full_lat = WIDTH + 2;
`ifdef INTCALC_SEQ_FASTMUL_EN
    localparam int c_mul_lat = 2;
`else
    localparam int c_mul_lat = WIDTH + 2;
`endif

    logic             clk     = 1'b0;
    logic             rst_ni  = 1'b0;
    logic             start_i = 1'b0;
    logic [2:0]       func_i  = '0;
    logic [WIDTH-1:0] in1_i   = '0;
    logic [WIDTH-1:0] in2_i   = '0;
    logic             flush_i = 1'b0;
    logic             busy_o;
    logic             done_o;
    logic [WIDTH-1:0] result_o;
    logic             divzero_o;
    logic             stall_o;

    intcalc_seq #(.WIDTH(WIDTH)) dut (
        .clk_i     (clk),
        .rst_ni    (rst_ni),
        .start_i   (start_i),
        .func_i    (func_i),
        .in1_i     (in1_i),
        .in2_i     (in2_i),
        .flush_i   (flush_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .result_o  (result_o),
        .divzero_o (divzero_o),
        .stall_o   (stall_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]       func;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] res;
        logic             dz;
        int               lat;
    } vec_t;

    typedef struct {
        logic [WIDTH-1:0] res;
        logic             dz;
        int               lat;
    } exp_t;

    localparam int NV = 21;
    vec_t             vecs[NV];
    exp_t             sb_q[$];
    int               checks = 0;
    int               errors = 0;
    logic [WIDTH-1:0] last_res = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive a request in the current (negedge) slot; optionally queue its expectation
    task automatic issue(input logic [2:0] f, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input bit push, input logic [WIDTH-1:0] res, input logic dz, input int lat);
        exp_t e;
        start_i = 1'b1;
        func_i  = f;
        in1_i   = a;
        in2_i   = b;
        if (push) begin
            e.res = res;
            e.dz  = dz;
            e.lat = lat;
            sb_q.push_back(e);
        end
    endtask

    // Wait for done_o after the acceptance edge; poke_cyc re-asserts start mid-operation
    task automatic wait_result(input string tag, input int poke_cyc);
        int   n;
        bit   seen;
        int   busy_bad;
        exp_t e;
        n = 0;
        seen = 1'b0;
        busy_bad = 0;
        @(posedge clk);
        while (!seen && n < 200) begin
            @(negedge clk);
            n++;
            if (n == poke_cyc) begin
                start_i = 1'b1;
                func_i  = 3'd0;
                in1_i   = 32'd3;
                in2_i   = 32'd3;
            end else begin
                start_i = 1'b0;
            end
            if (done_o) seen = 1'b1;
            else if (!busy_o || !stall_o) busy_bad++;
        end
        check({tag, "_done_seen"}, 64'(seen), 64'd1);
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_scoreboard: got empty queue expected one entry", tag);
        end else begin
            e = sb_q.pop_front();
            if (seen) begin
                check({tag, "_latency"}, 64'(n), 64'(e.lat));
                check({tag, "_result"}, 64'(result_o), 64'(e.res));
                check({tag, "_divzero"}, 64'(divzero_o), 64'(e.dz));
                check({tag, "_busy"}, 64'(busy_bad), 64'd0);
                check({tag, "_busy_at_done"}, 64'(busy_o), 64'd0);
            end
            last_res = e.res;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int done_cnt;
        vecs[0]  = '{3'd4, 32'd100,        32'd7,        32'd14,         1'b0, c_full_lat};
        vecs[1]  = '{3'd6, 32'd100,        32'd7,        32'd2,          1'b0, c_full_lat};
        vecs[2]  = '{3'd3, 32'hFFFFFF9C,   32'd7,        32'hFFFFFFF2,   1'b0, c_full_lat};
        vecs[3]  = '{3'd5, 32'hFFFFFF9C,   32'd7,        32'hFFFFFFFE,   1'b0, c_full_lat};
        vecs[4]  = '{3'd3, 32'h80000000,   32'hFFFFFFFF, 32'h80000000,   1'b0, c_full_lat};
        vecs[5]  = '{3'd5, 32'h80000000,   32'hFFFFFFFF, 32'h00000000,   1'b0, c_full_lat};
        vecs[6]  = '{3'd4, 32'd5,          32'd0,        32'hFFFFFFFF,   1'b1, 2};
        vecs[7]  = '{3'd6, 32'd5,          32'd0,        32'd5,          1'b1, 2};
        vecs[8]  = '{3'd3, 32'hFFFFFF9C,   32'd0,        32'hFFFFFFFF,   1'b1, 2};
        vecs[9]  = '{3'd5, 32'hFFFFFF9C,   32'd0,        32'hFFFFFF9C,   1'b1, 2};
        vecs[10] = '{3'd1, 32'hFFFFFFFF,   32'd2,        32'hFFFFFFFF,   1'b0, c_mul_lat};
        vecs[11] = '{3'd2, 32'hFFFFFFFF,   32'd2,        32'h00000001,   1'b0, c_mul_lat};
        vecs[12] = '{3'd0, 32'hFFFFFFFF,   32'd2,        32'hFFFFFFFE,   1'b0, c_mul_lat};
        vecs[13] = '{3'd0, 32'd12345,      32'd6789,     32'h04FED79D,   1'b0, c_mul_lat};
        vecs[14] = '{3'd2, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE,   1'b0, c_mul_lat};
        vecs[15] = '{3'd1, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'h00000000,   1'b0, c_mul_lat};
        vecs[16] = '{3'd3, 32'd7,          32'hFFFFFFFE, 32'hFFFFFFFD,   1'b0, c_full_lat};
        vecs[17] = '{3'd5, 32'd7,          32'hFFFFFFFE, 32'h00000001,   1'b0, c_full_lat};
        vecs[18] = '{3'd7, 32'h1234,       32'h5678,     32'h00000000,   1'b0, 2};
        vecs[19] = '{3'd4, 32'hFFFFFFFF,   32'd1,        32'hFFFFFFFF,   1'b0, c_full_lat};
        vecs[20] = '{3'd1, 32'h80000000,   32'h80000000, 32'h40000000,   1'b0, c_mul_lat};

        // Reset state, with start_i held high to show stall_o is gated by reset
        start_i = 1'b1;
        #2;
        check("rst_busy",    64'(busy_o),    64'd0);
        check("rst_done",    64'(done_o),    64'd0);
        check("rst_divzero", 64'(divzero_o), 64'd0);
        check("rst_stall",   64'(stall_o),   64'd0);
        check("rst_result",  64'(result_o),  64'd0);

        // Release reset and request on the same slot: first edge must accept
        @(negedge clk);
        rst_ni = 1'b1;
        for (int i = 0; i < NV; i++) begin
            if (i > 0) @(negedge clk);
            issue(vecs[i].func, vecs[i].a, vecs[i].b, 1'b1, vecs[i].res, vecs[i].dz, vecs[i].lat);
            wait_result($sformatf("vec%0d", i), -1);
        end

        // Result holds while idle
        repeat (3) @(negedge clk);
        check("result_hold", 64'(result_o), 64'(last_res));

        // start_i during CALC is ignored
        @(negedge clk);
        issue(3'd4, 32'd100, 32'd7, 1'b1, 32'd14, 1'b0, c_full_lat);
        wait_result("poke", 5);

        // Back-to-back: new start in the DONE cycle
        @(negedge clk);
        issue(3'd6, 32'd100, 32'd7, 1'b1, 32'd2, 1'b0, c_full_lat);
        wait_result("b2b0", -1);
        issue(3'd4, 32'd100, 32'd7, 1'b1, 32'd14, 1'b0, c_full_lat);
        #1;
        check("b2b_stall_in_done", 64'(stall_o), 64'd1);
        wait_result("b2b1", -1);

        // Flush at cycle 10 of a DIVU
        @(negedge clk);
        issue(3'd4, 32'd7, 32'd1, 1'b0, '0, 1'b0, 0);
        @(posedge clk);
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            start_i = 1'b0;
            if (n == 10) flush_i = 1'b1;
        end
        @(negedge clk);
        flush_i = 1'b0;
        check("flush_busy",   64'(busy_o),   64'd0);
        check("flush_done",   64'(done_o),   64'd0);
        check("flush_result", 64'(result_o), 64'(last_res));
        done_cnt = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done_o) done_cnt++;
        end
        check("flush_no_done",      64'(done_cnt), 64'd0);
        check("flush_result_later", 64'(result_o), 64'(last_res));

        // Asynchronous reset mid-CALC, then a start on the first edge after release
        @(negedge clk);
        issue(3'd4, 32'd100, 32'd3, 1'b0, '0, 1'b0, 0);
        @(posedge clk);
        repeat (5) @(negedge clk);
        start_i = 1'b0;
        #2;
        rst_ni  = 1'b0;
        start_i = 1'b1;
        #1;
        check("arst_busy",    64'(busy_o),    64'd0);
        check("arst_done",    64'(done_o),    64'd0);
        check("arst_divzero", 64'(divzero_o), 64'd0);
        check("arst_stall",   64'(stall_o),   64'd0);
        check("arst_result",  64'(result_o),  64'd0);
        @(negedge clk);
        rst_ni = 1'b1;
        issue(3'd4, 32'd1000, 32'd10, 1'b1, 32'd100, 1'b0, c_full_lat);
        wait_result("post_rst", -1);

        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/intcalc_seq.md
INTCALC_SEQ -- requirements
Module: intcalc_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width in bits; legal values are even and 8..64.
REQ-002 The block SHALL have port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_ni, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port start_i, input, 1 bit: operation request.
REQ-005 The block SHALL have port func_i, input, 3 bits: 0 MUL (low half), 1 MULH (signed high), 2 MULHU (unsigned high), 3 DIV, 4 DIVU, 5 MOD, 6 MODU, 7 reserved.
REQ-006 The block SHALL have ports in1_i and in2_i, input, WIDTH bits each: multiplicand/dividend and multiplier/divisor.
REQ-007 The block SHALL have port flush_i, input, 1 bit: abort the operation in flight.
REQ-008 The block SHALL have port busy_o, output, 1 bit: an operation is in flight.
REQ-009 The block SHALL have port done_o, output, 1 bit: one-cycle result-valid pulse.
REQ-010 The block SHALL have port result_o, output, WIDTH bits: last completed result.
REQ-011 The block SHALL have port divzero_o, output, 1 bit: pulses with done_o when the divisor was zero.
REQ-012 The block SHALL have port stall_o, output, 1 bit: pipeline hold request to the execute stage.

Function
REQ-013 The FSM SHALL have states IDLE, CALC, FIXUP and DONE.
REQ-014 start_i SHALL be accepted only in IDLE or DONE; accepting it latches func_i, in1_i and in2_i and enters CALC with the iteration counter set to WIDTH.
REQ-015 start_i SHALL be ignored while the FSM is in CALC or FIXUP.
REQ-016 Each CALC cycle SHALL process one operand bit: shift-add for multiply, restoring subtract for divide, on operand magnitudes with a 2*WIDTH-bit accumulator; the counter decrements and the FSM enters FIXUP when the counter reaches 0.
REQ-017 FIXUP SHALL apply sign correction (quotient negated if operand signs differ, remainder takes the dividend sign), select the low or high half, and register result_o; the FSM then enters DONE.
REQ-018 DONE SHALL assert done_o for exactly one cycle, then return to IDLE unless a new start is accepted in that cycle.
REQ-019 Latency SHALL be WIDTH+2 cycles from the start_i acceptance edge to done_o high for ops 0-6.
REQ-020 Divisor zero SHALL bypass CALC (start -> FIXUP -> DONE, latency 2) and give quotient all-ones, remainder = in1, and divzero_o=1 with done_o.
REQ-021 Signed overflow (DIV or MOD with most-negative dividend and divisor -1) SHALL give quotient = most-negative value and remainder 0, with no flag.
REQ-022 func_i=7 SHALL follow the divide-by-zero path timing and give result 0 with divzero_o=0.
REQ-023 result_o SHALL hold its value until the next FIXUP.
REQ-024 busy_o SHALL be 1 exactly in CALC and FIXUP.
REQ-025 stall_o SHALL equal busy_o OR (start_i AND state in {IDLE, DONE}), so the requesting instruction is held until done_o.
REQ-026 flush_i SHALL force IDLE on the next edge with no done_o and result_o unchanged; flush_i SHALL override a simultaneous start_i.

Reset
REQ-027 While rst_ni=0, the FSM SHALL be in IDLE, the counter 0, busy_o, done_o, divzero_o and stall_o 0, and result_o 0; assertion mid-operation SHALL discard the operation.
REQ-028 The first start_i SHALL be accepted on the first rising edge after rst_ni deasserts.

Configuration
REQ-029 With macro INTCALC_SEQ_FASTMUL_EN defined, ops 0-2 SHALL use a single-cycle combinational WIDTH x WIDTH multiplier and bypass CALC, for a latency of 2; divide behaviour is unchanged.
REQ-030 Without INTCALC_SEQ_FASTMUL_EN, no combinational multiplier SHALL exist and ops 0-2 SHALL use the iterative path with latency WIDTH+2.

Verification
REQ-031 WIDTH=32, DIVU 100/7 -> done_o at cycle 34 after start, result 14; MODU repeat -> 2.
REQ-032 DIV -100/7 -> result 0xFFFFFFF2 (-14); MOD -100/7 -> 0xFFFFFFFE (-2); DIV 0x80000000/0xFFFFFFFF -> 0x80000000, divzero_o=0.
REQ-033 DIVU 5/0 -> done_o 2 cycles after start, result 0xFFFFFFFF, divzero_o=1; MODU 5/0 -> 5.
REQ-034 MULH 0xFFFFFFFF*2 -> 0xFFFFFFFF, MULHU -> 1, MUL -> 0xFFFFFFFE; latency 34 without the macro and 2 with INTCALC_SEQ_FASTMUL_EN.
REQ-035 flush_i at cycle 10 of a DIVU -> no done_o, busy_o=0 next cycle, result_o unchanged; start_i during CALC ignored; start_i in the DONE cycle gives back-to-back results.
REQ-036 rst_ni low mid-CALC -> all outputs 0 asynchronously; start on the first edge after release completes normally.
